// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock with a
// start/busy/done handshake; divide-by-zero resolves in a single cycle.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   t;
    logic             ge;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // The stored partial remainder is always < divisor, so its top bit is
    // provably zero; only the shifted trial value needs the extra bit.
    always_comb begin
        t      = {r, q[WIDTH-1]};
        ge     = (t >= {1'b0, d});
        r_next = ge ? WIDTH'(t - {1'b0, d}) : t[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            r         <= '0;
            q         <= '0;
            d         <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            dbz       <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            r     <= '0;
                            q     <= dividend;
                            d     <= divisor;
                            count <= '0;
                        end
                    end
                end
                CALC: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                        dbz       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed table, handshake
// corner cases, exhaustive sweep and random operands against an arithmetic model.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    int checks;
    int errors;
    int done_count;
    int busy_count;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_count++;
        if (busy) busy_count++;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_div(input int a, input int b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = W'((1 << W) - 1);
            r = W'(a);
            z = 1'b1;
        end else begin
            q = W'(a / b);
            r = W'(a % b);
            z = 1'b0;
        end
    endfunction

    // Drive a start for one edge, then scramble the operand inputs.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // n = number of falling edges since acceptance at which done is first seen.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic ez, input string tag);
        int n;
        int b0;
        b0 = busy_count;
        issue(a, b);
        wait_done(1, n);
        chk({tag, ".latency"}, 32'(n), ez ? 32'd1 : 32'(W + 1));
        chk({tag, ".quotient"}, 32'(quotient), 32'(eq));
        chk({tag, ".remainder"}, 32'(remainder), 32'(er));
        chk({tag, ".dbz"}, 32'(dbz), 32'(ez));
        chk({tag, ".busy_cycles"}, 32'(busy_count - b0), ez ? 32'd0 : 32'(W));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int dc;
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         mz;

        checks = 0;
        errors = 0;
        done_count = 0;
        busy_count = 0;

        tbl[0] = '{a: 4'd9,  b: 4'd2,  q: 4'd4,  r: 4'd1, z: 1'b0};
        tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
        tbl[2] = '{a: 4'd3,  b: 4'd5,  q: 4'd0,  r: 4'd3, z: 1'b0};
        tbl[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
        tbl[4] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, z: 1'b1};
        tbl[5] = '{a: 4'd6,  b: 4'd3,  q: 4'd2,  r: 4'd0, z: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.quotient", 32'(quotient), 32'd0);
        chk("reset.remainder", 32'(remainder), 32'd0);
        chk("reset.dbz", 32'(dbz), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_check(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, $sformatf("tbl%0d", i));

        // Start pulsed mid-operation must be ignored.
        dc = done_count;
        issue(4'd9, 4'd2);
        @(negedge clk);
        dividend = 4'd8;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, n);
        chk("ignore.latency", 32'(n), 32'(W + 1));
        chk("ignore.quotient", 32'(quotient), 32'd4);
        chk("ignore.remainder", 32'(remainder), 32'd1);
        repeat (8) @(negedge clk);
        chk("ignore.done_count", 32'(done_count - dc), 32'd1);
        chk("ignore.busy", 32'(busy), 32'd0);

        // Back-to-back: new start held during the DONE cycle.
        issue(4'd6, 4'd3);
        wait_done(1, n);
        chk("b2b.first_q", 32'(quotient), 32'd2);
        dividend = 4'd14;
        divisor  = 4'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        chk("b2b.busy_after_accept", 32'(busy), 32'd1);
        wait_done(1, n);
        chk("b2b.latency", 32'(n), 32'(W + 1));
        chk("b2b.quotient", 32'(quotient), 32'd3);
        chk("b2b.remainder", 32'(remainder), 32'd2);
        @(negedge clk);

        // Reset two cycles into a division aborts it with no done pulse.
        issue(4'd13, 4'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.quotient", 32'(quotient), 32'd0);
        chk("abort.remainder", 32'(remainder), 32'd0);
        chk("abort.dbz", 32'(dbz), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dc = done_count;
        repeat (8) @(negedge clk);
        chk("abort.no_done", 32'(done_count - dc), 32'd0);
        run_check(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, "abort.redo");

        // 2x2 multiplier products divide back to the other operand exactly.
        for (int a = 0; a < 4; a++)
            for (int b = 1; b < 4; b++)
                run_check(W'(a * b), W'(b), W'(a), '0, 1'b0, $sformatf("mul%0dx%0d", a, b));

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                ref_div(a, b, mq, mr, mz);
                run_check(W'(a), W'(b), mq, mr, mz, $sformatf("sweep%0d/%0d", a, b));
            end

        for (int i = 0; i < 100; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            ref_div(a, b, mq, mr, mz);
            run_check(W'(a), W'(b), mq, mr, mz, $sformatf("rand%0d/%0d", a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider. It is the inverse of the team's combinational 2x2 multiplier.
- It takes a WIDTH-bit dividend and a WIDTH-bit divisor and returns the quotient and remainder after WIDTH clock cycles.
- It uses a start/busy/done handshake.
- It sits beside the arithmetic gate-level blocks and checks multiplier products: product / operand must give the other operand with a remainder of 0.

Parameters:
- WIDTH, default 4, bit width of dividend, divisor, quotient and remainder (WIDTH >= 2).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only when busy=0.
- dividend  input  WIDTH  unsigned dividend; captured on an accepted start.
- divisor  input  WIDTH  unsigned divisor; captured on an accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; quotient, remainder and dbz are valid from this cycle onward.
- quotient  output  WIDTH  result quotient; registered, held until the next completion.
- remainder  output  WIDTH  result remainder; registered, held until the next completion.
- dbz  output  1  divide-by-zero flag for the latest result; held like quotient.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, dbz=0.
  - All internal registers cleared.
- States: IDLE, CALC, DONE.
  - busy=1 only in CALC.
  - done=1 only in DONE.
- Start acceptance:
  - start is accepted on a rising edge when the state is IDLE or DONE. This allows back-to-back operations.
  - start is ignored in CALC, with no effect on the operation in flight.
- Accepted start with divisor != 0:
  - Load partial remainder R = 0 (WIDTH+1 bits).
  - Load shift register Q = dividend and latch D = divisor.
  - Set count = 0 and go to CALC.
- CALC, one iteration per edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If T >= D: R = T - D and Q = {Q[WIDTH-2:0], 1}.
  - Otherwise: R = T and Q = {Q[WIDTH-2:0], 0}.
  - count increments each iteration.
  - On the WIDTH-th iteration edge: load quotient = final Q, remainder = final R[WIDTH-1:0], dbz = 0, and go to DONE.
- Accepted start with divisor == 0:
  - Go directly to DONE on that edge.
  - Set quotient = all ones, remainder = dividend, dbz = 1.
- DONE lasts exactly one cycle. On the next edge it goes to CALC if a new start is accepted, otherwise to IDLE.
- Latency, with start accepted at edge E0:
  - Normal division: done is high in the cycle following edge E0+WIDTH. With WIDTH=4, that is 4 clocks after acceptance.
  - Divide by zero: done is high in the cycle following E0 (1 clock).
- Output holding:
  - quotient, remainder and dbz change only on the edge that enters DONE.
  - During CALC they keep the previous result.
- Arithmetic:
  - Unsigned only.
  - R holds WIDTH+1 bits so the compare and subtract never overflow.
  - The final remainder is always < divisor.
- Boundaries:
  - dividend < divisor gives quotient 0 and remainder = dividend.
  - divisor = 1 gives quotient = dividend and remainder 0.
  - dividend = 0 gives 0, 0.
  - Max/max (e.g. 15/15) gives 1, 0.
- Reset mid-operation: rst_n low during CALC aborts immediately. All outputs return to reset values and no done pulse is produced.
- Input changes:
  - dividend and divisor may change freely after acceptance.
  - Only the values captured at acceptance are used.

Test Plan:
- WIDTH=4, after reset: start with 9/2 -> busy high 4 cycles; done pulses once; quotient=4, remainder=1, dbz=0.
- 15/1 -> quotient=15, remainder=0. Then 3/5 -> quotient=0, remainder=3. Then 15/15 -> quotient=1, remainder=0.
- Divide by zero: 7/0 -> done in the next cycle, busy never high; quotient=15, remainder=7, dbz=1. A following 6/3 clears dbz -> quotient=2, remainder=0.
- Start pulsed with 8/3 during CALC of 9/2 -> ignored; result is 4 r1; no second done.
- Back-to-back: start 14/4 held high in the DONE cycle of the previous operation -> accepted; next done gives quotient=3, remainder=2.
  - Exhaustive sweep of all 256 operand pairs against a reference model.
  - Every multiplier product (a*b)/b with b != 0 gives a, remainder 0.
- Reset mid-CALC: rst_n low 2 cycles into 13/3 -> busy=0, done=0, quotient=0, remainder=0, dbz=0 asynchronously; no done afterwards. A new 13/3 gives quotient=4, remainder=1.
